// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit:
// opcodes, FSM states, datapath select encodings, strobe bundle.
package ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    RWB, BRANCH, IMMEXEC, IMMWB, JUMP, ILLEGAL, HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_XOR
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_B, SRCB_4, SRCB_IMM, SRCB_IMM4
  } srcb_t;

  typedef enum logic [1:0] {
    PC_ALU, PC_ALUOUT, PC_JUMP, PC_RSVD
  } pcsrc_t;

  typedef struct packed {
    logic       PCWrite;
    logic       PCWriteCond;
    logic       BranchNe;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic       SignZero;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle: opcode and memory
// handshake in, strobes/selects and status out.
interface multicycle_control_if;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNe;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic       SignZero;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       illegal;
  logic       fault;
  logic [3:0] state;

  modport master (
    input  Opcode, mem_ready,
    output PCWrite, PCWriteCond, BranchNe, IorD,
    output MemRead, MemWrite, MemtoReg, IRWrite,
    output ALUSrcA, RegWrite, RegDst, SignZero,
    output ALUSrcB, ALUOp, PCSource,
    output illegal, fault, state
  );

  modport slave (
    output Opcode, mem_ready,
    input  PCWrite, PCWriteCond, BranchNe, IorD,
    input  MemRead, MemWrite, MemtoReg, IRWrite,
    input  ALUSrcA, RegWrite, RegDst, SignZero,
    input  ALUSrcB, ALUOp, PCSource,
    input  illegal, fault, state
  );
endinterface

// File: rtl/ctrl_output_decode.sv
// Combinational state -> datapath strobe map. Moore except
// FETCH's IRWrite/PCWrite, which follow mem_ready.
module ctrl_output_decode
  import ctrl_pkg::*;
(
  input  state_t state,
  input  logic   lat_bne,
  input  logic   lat_xori,
  input  logic   mem_ready,
  input  logic   reset_n,
  output ctrl_t  ctrl
);

  // Per-state strobes, all forced low while in reset.
  always_comb begin
    ctrl = '0;
    unique case (state)
      FETCH: begin
        ctrl.MemRead = 1'b1;
        ctrl.ALUSrcB = SRCB_4;
        ctrl.IRWrite = mem_ready;
        ctrl.PCWrite = mem_ready;
      end
      DECODE:
        ctrl.ALUSrcB = SRCB_IMM4;
      MEMADR: begin
        ctrl.ALUSrcA = 1'b1;
        ctrl.ALUSrcB = SRCB_IMM;
      end
      MEMRD: begin
        ctrl.MemRead = 1'b1;
        ctrl.IorD    = 1'b1;
      end
      MEMWB: begin
        ctrl.RegWrite = 1'b1;
        ctrl.MemtoReg = 1'b1;
      end
      MEMWR: begin
        ctrl.MemWrite = 1'b1;
        ctrl.IorD     = 1'b1;
      end
      EXEC: begin
        ctrl.ALUSrcA = 1'b1;
        ctrl.ALUOp   = ALU_FUNCT;
      end
      RWB: begin
        ctrl.RegWrite = 1'b1;
        ctrl.RegDst   = 1'b1;
      end
      BRANCH: begin
        ctrl.ALUSrcA     = 1'b1;
        ctrl.ALUOp       = ALU_SUB;
        ctrl.PCWriteCond = 1'b1;
        ctrl.PCSource    = PC_ALUOUT;
        ctrl.BranchNe    = lat_bne;
      end
      IMMEXEC: begin
        ctrl.ALUSrcA  = 1'b1;
        ctrl.ALUSrcB  = SRCB_IMM;
        ctrl.ALUOp    = lat_xori ? ALU_XOR : ALU_ADD;
        ctrl.SignZero = lat_xori;
      end
      IMMWB: begin
        ctrl.RegWrite = 1'b1;
        ctrl.ALUOp    = lat_xori ? ALU_XOR : ALU_ADD;
        ctrl.SignZero = lat_xori;
      end
      JUMP: begin
        ctrl.PCWrite  = 1'b1;
        ctrl.PCSource = PC_JUMP;
      end
      ILLEGAL:
        ctrl.illegal = 1'b1;
      default: ;
    endcase
    if (!reset_n) ctrl = '0;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, memory wait
// watchdog, sticky fault and opcode-bit latches.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic               clk,
  input logic               reset_n,
  multicycle_control_if.master bus
);

  state_t     state_q;
  state_t     state_d;
  logic [CNT_W-1:0] cnt_q;
  logic       fault_q;
  logic       lat_sw;
  logic       lat_bne;
  logic       lat_xori;
  logic       mem_wait;
  ctrl_t      ctrl;

  assign mem_wait = (state_q == FETCH || state_q == MEMRD ||
                     state_q == MEMWR) && !bus.mem_ready;

  // Next-state selection, with watchdog override.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        unique case (bus.Opcode)
          OP_LW, OP_SW:     state_d = MEMADR;
          OP_R:             state_d = EXEC;
          OP_BEQ, OP_BNE:   state_d = BRANCH;
          OP_ADDI, OP_XORI: state_d = IMMEXEC;
          OP_J:             state_d = JUMP;
          default:          state_d = ILLEGAL;
        endcase
      end
      MEMADR:  state_d = lat_sw ? MEMWR : MEMRD;
      MEMRD:   if (bus.mem_ready) state_d = MEMWB;
      MEMWB:   state_d = FETCH;
      MEMWR:   if (bus.mem_ready) state_d = FETCH;
      EXEC:    state_d = RWB;
      RWB:     state_d = FETCH;
      BRANCH:  state_d = FETCH;
      IMMEXEC: state_d = IMMWB;
      IMMWB:   state_d = FETCH;
      JUMP:    state_d = FETCH;
      ILLEGAL: state_d = FETCH;
      default: state_d = HALT;
    endcase
    if (mem_wait && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))
      state_d = HALT;
  end

  // State, wait counter, sticky fault, decode-time latches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FETCH;
      cnt_q    <= '0;
      fault_q  <= 1'b0;
      lat_sw   <= 1'b0;
      lat_bne  <= 1'b0;
      lat_xori <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) cnt_q <= '0;
      else if (mem_wait)      cnt_q <= cnt_q + CNT_W'(1);
      if (state_d == HALT) fault_q <= 1'b1;
      if (state_q == DECODE) begin
        lat_sw   <= bus.Opcode == OP_SW;
        lat_bne  <= bus.Opcode == OP_BNE;
        lat_xori <= bus.Opcode == OP_XORI;
      end
    end
  end

  ctrl_output_decode u_dec (
    .state     (state_q),
    .lat_bne   (lat_bne),
    .lat_xori  (lat_xori),
    .mem_ready (bus.mem_ready),
    .reset_n   (reset_n),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite     = ctrl.PCWrite;
  assign bus.PCWriteCond = ctrl.PCWriteCond;
  assign bus.BranchNe    = ctrl.BranchNe;
  assign bus.IorD        = ctrl.IorD;
  assign bus.MemRead     = ctrl.MemRead;
  assign bus.MemWrite    = ctrl.MemWrite;
  assign bus.MemtoReg    = ctrl.MemtoReg;
  assign bus.IRWrite     = ctrl.IRWrite;
  assign bus.ALUSrcA     = ctrl.ALUSrcA;
  assign bus.RegWrite    = ctrl.RegWrite;
  assign bus.RegDst      = ctrl.RegDst;
  assign bus.SignZero    = ctrl.SignZero;
  assign bus.ALUSrcB     = ctrl.ALUSrcB;
  assign bus.ALUOp       = ctrl.ALUOp;
  assign bus.PCSource    = ctrl.PCSource;
  assign bus.illegal     = ctrl.illegal;
  assign bus.fault       = fault_q & reset_n;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table of instruction
// vectors, randomized instruction stream, corner sequences.
module tb_multicycle_control;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] XORI = 6'b001110;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [3:0] ST_FETCH = 4'd0;
  localparam logic [3:0] ST_HALT  = 4'd13;

  typedef struct {
    int cyc;
    int rw;
    int rd;
    int mw;
    int mr;
    int irw;
    int pcw;
    int pcwc;
    int bne;
    int ill;
    int xo;
    int sz;
  } cnt_t;

  typedef struct {
    logic [5:0] op;
    int         f;
    int         m;
    cnt_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  multicycle_control_if bus ();

  multicycle_control #(.TIMEOUT_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] outs();
    return {bus.PCWrite, bus.PCWriteCond, bus.BranchNe,
            bus.IorD, bus.MemRead, bus.MemWrite,
            bus.MemtoReg, bus.IRWrite, bus.ALUSrcA,
            bus.RegWrite, bus.RegDst, bus.SignZero,
            bus.ALUSrcB, bus.ALUOp, bus.PCSource,
            bus.illegal, bus.fault};
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic int is_mem(logic [5:0] op);
    return (op == LW || op == SW) ? 1 : 0;
  endfunction

  // Instruction-level expectations from the latency and
  // strobe rules: f fetch stalls, m memory-phase stalls.
  function automatic cnt_t model(logic [5:0] op, int f, int m);
    cnt_t e = '{default: 0};
    e.irw = 1;
    e.pcw = 1;
    e.mr  = f + 1;
    case (op)
      R:    begin e.cyc = 4; e.rw = 1; e.rd = 1; end
      LW:   begin e.cyc = 5 + m; e.rw = 1; e.mr += m + 1; end
      SW:   begin e.cyc = 4 + m; e.mw = m + 1; end
      BEQ:  begin e.cyc = 3; e.pcwc = 1; end
      BNE:  begin e.cyc = 3; e.pcwc = 1; e.bne = 1; end
      ADDI: begin e.cyc = 4; e.rw = 1; end
      XORI: begin e.cyc = 4; e.rw = 1; e.xo = 2; e.sz = 2; end
      J:    begin e.cyc = 3; e.pcw = 2; end
      default: begin e.cyc = 3; e.ill = 1; end
    endcase
    e.cyc += f;
    return e;
  endfunction

  // Runs one instruction; Opcode is only valid in DECODE,
  // random elsewhere. Counts strobe cycles over its span.
  task automatic run_instr(input logic [5:0] op, input int f,
                           input int m, input int ncyc,
                           output cnt_t a);
    int dec = f + 1;
    int ms  = f + 3;
    a = '{default: 0};
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      bus.mem_ready = !(c < f ||
        (is_mem(op) == 1 && c >= ms && c < ms + m));
      bus.Opcode = (c == dec) ? op : 6'($urandom);
      #1;
      if (c == 0) chk("start_in_fetch", int'(bus.state),
                      int'(ST_FETCH));
      a.cyc++;
      a.rw   += int'(bus.RegWrite);
      a.rd   += int'(bus.RegDst);
      a.mw   += int'(bus.MemWrite);
      a.mr   += int'(bus.MemRead);
      a.irw  += int'(bus.IRWrite);
      a.pcw  += int'(bus.PCWrite);
      a.pcwc += int'(bus.PCWriteCond);
      a.bne  += int'(bus.PCWriteCond & bus.BranchNe);
      a.ill  += int'(bus.illegal);
      a.xo   += int'(bus.ALUOp == 2'b11);
      a.sz   += int'(bus.SignZero);
      if (bus.fault) chk("no_fault", 1, 0);
    end
  endtask

  task automatic cmp_cnt(string t, cnt_t a, cnt_t e);
    chk({t, ".regwrite"}, a.rw, e.rw);
    chk({t, ".regdst"}, a.rd, e.rd);
    chk({t, ".memwrite"}, a.mw, e.mw);
    chk({t, ".memread"}, a.mr, e.mr);
    chk({t, ".irwrite"}, a.irw, e.irw);
    chk({t, ".pcwrite"}, a.pcw, e.pcw);
    chk({t, ".pcwritecond"}, a.pcwc, e.pcwc);
    chk({t, ".branchne"}, a.bne, e.bne);
    chk({t, ".illegal"}, a.ill, e.ill);
    chk({t, ".aluop_xor"}, a.xo, e.xo);
    chk({t, ".signzero"}, a.sz, e.sz);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    chk("reset_outputs", int'(outs()), 0);
    chk("reset_state", int'(bus.state), int'(ST_FETCH));
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  vec_t tbl[$];
  cnt_t act;
  cnt_t ex;

  initial begin
    bus.Opcode = R;
    bus.mem_ready = 1'b1;

    // Hand-computed instruction vectors.
    tbl.push_back('{R, 0, 0,
      '{4, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0}});
    tbl.push_back('{LW, 0, 0,
      '{5, 1, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0}});
    tbl.push_back('{LW, 0, 2,
      '{7, 1, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0}});
    tbl.push_back('{SW, 1, 1,
      '{6, 0, 0, 2, 2, 1, 1, 0, 0, 0, 0, 0}});
    tbl.push_back('{SW, 0, 3,
      '{7, 0, 0, 4, 1, 1, 1, 0, 0, 0, 0, 0}});
    tbl.push_back('{BNE, 0, 0,
      '{3, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0}});
    tbl.push_back('{BEQ, 0, 0,
      '{3, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0}});
    tbl.push_back('{ADDI, 2, 0,
      '{6, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0}});
    tbl.push_back('{XORI, 0, 0,
      '{4, 1, 0, 0, 1, 1, 1, 0, 0, 0, 2, 2}});
    tbl.push_back('{J, 3, 0,
      '{6, 0, 0, 0, 4, 1, 2, 0, 0, 0, 0, 0}});
    tbl.push_back('{6'b111111, 0, 0,
      '{3, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0}});

    // Reset held 3 cycles: everything low.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("reset_outputs", int'(outs()), 0);
      chk("reset_state", int'(bus.state), int'(ST_FETCH));
    end

    // First R instruction right out of reset.
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      bus.Opcode = R;
      bus.mem_ready = 1'b1;
      #1;
      chk("first_r_regwrite", int'(bus.RegWrite),
          (c == 3) ? 1 : 0);
      chk("first_r_regdst", int'(bus.RegDst),
          (c == 3) ? 1 : 0);
      if (c == 0) chk("first_fetch_memread",
                      int'(bus.MemRead), 1);
    end

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].f, tbl[i].m,
                tbl[i].e.cyc, act);
      cmp_cnt($sformatf("vec%0d", i), act, tbl[i].e);
    end

    // Randomized stream against the instruction model.
    for (int i = 0; i < 150; i++) begin
      logic [5:0] op;
      int f;
      int m;
      int k = int'($urandom_range(0, 8));
      case (k)
        0: op = R;    1: op = LW;   2: op = SW;
        3: op = BEQ;  4: op = BNE;  5: op = ADDI;
        6: op = XORI; 7: op = J;
        default: op = 6'($urandom);
      endcase
      f = int'($urandom_range(0, 3));
      m = int'($urandom_range(0, 3));
      ex = model(op, f, m);
      run_instr(op, f, m, ex.cyc, act);
      cmp_cnt($sformatf("rnd%0d", i), act, ex);
    end
    @(negedge clk);
    #1;
    chk("stream_end_fetch", int'(bus.state), int'(ST_FETCH));

    // Reset dropped during lw writeback.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      bus.Opcode = LW;
      bus.mem_ready = 1'b1;
      #1;
    end
    chk("lw_wb_regwrite", int'(bus.RegWrite), 1);
    chk("lw_wb_memtoreg", int'(bus.MemtoReg), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_regwrite", int'(bus.RegWrite), 0);
    chk("abort_outputs", int'(outs()), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("abort_state", int'(bus.state), int'(ST_FETCH));
    chk("abort_fetch_memread", int'(bus.MemRead), 1);

    // sw whose memory never answers: HALT after 4 waits.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      bus.Opcode = SW;
      bus.mem_ready = (c < 3);
      #1;
    end
    chk("wait4_memwrite", int'(bus.MemWrite), 1);
    chk("wait4_no_fault", int'(bus.fault), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.mem_ready = c[0];
      #1;
      chk("halt_state", int'(bus.state), int'(ST_HALT));
      chk("halt_fault", int'(bus.fault), 1);
      chk("halt_strobes", int'(outs() >> 1), 0);
    end
    do_reset();
    #1;
    chk("post_halt_fault", int'(bus.fault), 0);
    chk("post_halt_state", int'(bus.state), int'(ST_FETCH));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, want finish");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle MIPS main control unit. It replaces the single-cycle opcode decoder with a registered Moore state machine that sequences the shared datapath (single memory, single ALU, IR/MDR/A/B/ALUOut registers) through fetch, decode, execute, memory and writeback. It adds a ready handshake with variable-latency memory, a watchdog timeout, beq/addi support and illegal-opcode reporting.

## Interface
- TIMEOUT_CYCLES, 16: maximum cycles a memory state waits for mem_ready before faulting; must be ≥1.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): wait-counter width (derived; not overridden).
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Opcode  in  6  IR[31:26], sampled in DECODE.
- mem_ready  in  1  memory completed the current MemRead/MemWrite this cycle.
- PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, SignZero  out  1 each  datapath strobes/selects.
- ALUSrcB  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2.
- ALUOp  out  2  00 add, 01 sub, 10 funct, 11 xor.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- illegal  out  1  one-cycle pulse on unsupported opcode.
- fault  out  1  sticky memory-timeout flag.
- state  out  4  current state encoding, for debug.

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, xori 001110, j 000010.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready (Mealy on mem_ready only). The FSM advances to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Opcode: lw/sw→MEMADR, R→EXEC, beq/bne→BRANCH, addi/xori→IMMEXEC, j→JUMP, other→ILLEGAL.
- MEMADR: ALUSrcA=1, ALUSrcB=10, SignZero=0. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Next is FETCH.
- MEMWR: MemWrite=1, IorD=1. Waits for mem_ready, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next is RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Next is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, BranchNe=1 for bne and 0 for beq (latched in DECODE). Next is FETCH.
- IMMEXEC: ALUSrcA=1, ALUSrcB=10. addi uses ALUOp=00, SignZero=0; xori uses ALUOp=11, SignZero=1 (opcode latched in DECODE). Next is IMMWB.
- IMMWB: RegWrite=1, RegDst=0, MemtoReg=0, with ALUOp/SignZero held. Next is FETCH.
- JUMP: PCWrite=1, PCSource=10. Next is FETCH.
- ILLEGAL: illegal=1, no write strobes. Next is FETCH; the PC has already advanced.
- HALT: all strobes 0, fault=1. Left only by reset.
- Any output not listed for a state is 0.

## Timing
- State register is async-cleared to FETCH. Wait counter is cleared to 0. fault and the latched opcode bits are cleared to 0.
- While reset_n=0, every output is 0 (strobes gated with reset_n), including MemRead in FETCH.
- First FETCH strobes appear in the first cycle after reset_n rises.
- Minimum latencies with mem_ready held at 1:
  - j, beq, bne: 3 cycles.
  - R, sw, addi, xori: 4 cycles.
  - lw: 5 cycles.
  - Each memory state adds one cycle per mem_ready=0 cycle.
- Wait counter:
  - Increments each cycle in FETCH/MEMRD/MEMWR while mem_ready=0.
  - Clears on any state change.
  - If it reaches TIMEOUT_CYCLES with mem_ready still 0, the next state is HALT and fault sets.
  - mem_ready=1 in the same cycle the count reaches TIMEOUT_CYCLES counts as success; there is no fault.
- Opcode is sampled only in DECODE; changes elsewhere are ignored.
- Reset asserted mid-instruction aborts immediately: no further strobes, and no partial writeback is completed.

## Structure
- Package ctrl_pkg holds:
  - opcode localparams;
  - the state enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, IMMEXEC, IMMWB, JUMP, ILLEGAL, HALT);
  - ALUOp, ALUSrcB and PCSource encodings.
- Sub-module ctrl_output_decode: purely combinational map from {state, latched opcode bits, mem_ready, reset_n} to the control outputs. The top holds the state register, the wait counter and fault.

## Test plan
- Reset low 3 cycles, then high, mem_ready=1, Opcode=000000 → all outputs 0 during reset. Then FETCH, DECODE, EXEC, RWB, with RegWrite=1 and RegDst=1 only in cycle 4.
- lw with mem_ready low for 2 cycles in MEMRD → total 7 cycles. MemRead=1 and IorD=1 throughout MEMRD; MemtoReg=1 and RegWrite=1 in the final cycle.
- bne then beq → 3 cycles each; PCWriteCond=1 in cycle 3 with BranchNe 1 then 0. xori → SignZero=1 and ALUOp=11 in cycles 3–4.
- Opcode=111111 → illegal pulses for exactly 1 cycle in cycle 3, with no RegWrite/MemWrite, then FETCH.
- TIMEOUT_CYCLES=4, mem_ready=0 in MEMWR → HALT after 4 waiting cycles with fault=1 and all strobes 0. Stays there until reset_n pulses low, after which fault=0.
- reset_n dropped in the MEMWB cycle of lw → RegWrite deasserts asynchronously and the state is FETCH on release.
